// File: rtl/lda_polyline_sequencer.sv
// Polyline sequencer: buffers vertices in a first-word-fall-through FIFO and turns each
// consecutive vertex pair into one go/done request for the line-drawing engine.
module lda_polyline_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       v_push,
  input  logic [8:0] v_x,
  input  logic [7:0] v_y,
  input  logic [2:0] v_colour,
  input  logic       v_last,
  output logic       fifo_full,
  output logic       overflow,
  output logic       busy,
  output logic       poly_done,
  output logic       lda_go,
  output logic [8:0] lda_x0,
  output logic [8:0] lda_x1,
  output logic [7:0] lda_y0,
  output logic [7:0] lda_y1,
  output logic [2:0] lda_colour,
  input  logic       lda_done
);

  // state   | meaning
  // S_START | idle, next vertex popped begins a new polyline
  // S_NEXT  | inside a polyline, next vertex popped closes a segment
  // S_ISSUE | lda_go high for exactly this cycle
  // S_ACK   | lda_done ignored, engine may still show a stale done
  // S_WAIT  | waiting for lda_done from the engine
  typedef enum logic [2:0] {S_START, S_NEXT, S_ISSUE, S_ACK, S_WAIT} state_t;

  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [20:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  state_t        r_state;
  logic [8:0]    r_prev_x;
  logic [7:0]    r_prev_y;
  logic          r_end;
  logic          r_poly_done;
  logic          r_lda_go;
  logic [8:0]    r_lda_x0;
  logic [8:0]    r_lda_x1;
  logic [7:0]    r_lda_y0;
  logic [7:0]    r_lda_y1;
  logic [2:0]    r_lda_colour;

  logic          w_empty;
  logic          w_full;
  logic          w_push_ok;
  logic          w_pop;
  logic [20:0]   w_head;
  logic [8:0]    w_head_x;
  logic [7:0]    w_head_y;
  logic [2:0]    w_head_colour;
  logic          w_head_last;

  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == C_FULL);
  assign w_push_ok     = v_push & ~w_full;
  assign w_pop         = ((r_state == S_START) || (r_state == S_NEXT)) & ~w_empty;
  assign w_head        = r_mem[r_rd_ptr];
  assign w_head_x      = w_head[8:0];
  assign w_head_y      = w_head[16:9];
  assign w_head_colour = w_head[19:17];
  assign w_head_last   = w_head[20];

  // Storage needs no reset: r_count alone decides which entries are valid.
  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= {v_last, v_colour, v_y, v_x};
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= v_push & w_full;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state      <= S_START;
      r_prev_x     <= '0;
      r_prev_y     <= '0;
      r_end        <= 1'b0;
      r_poly_done  <= 1'b0;
      r_lda_go     <= 1'b0;
      r_lda_x0     <= '0;
      r_lda_x1     <= '0;
      r_lda_y0     <= '0;
      r_lda_y1     <= '0;
      r_lda_colour <= '0;
    end else begin
      r_lda_go    <= 1'b0;
      r_poly_done <= 1'b0;
      case (r_state)
        S_START: begin
          if (!w_empty) begin
            r_prev_x <= w_head_x;
            r_prev_y <= w_head_y;
            // A lone terminating vertex is drawn as a zero-length line.
            if (w_head_last) begin
              r_lda_x0     <= w_head_x;
              r_lda_x1     <= w_head_x;
              r_lda_y0     <= w_head_y;
              r_lda_y1     <= w_head_y;
              r_lda_colour <= w_head_colour;
              r_end        <= 1'b1;
              r_lda_go     <= 1'b1;
              r_state      <= S_ISSUE;
            end else begin
              r_state <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if (!w_empty) begin
            r_lda_x0     <= r_prev_x;
            r_lda_y0     <= r_prev_y;
            r_lda_x1     <= w_head_x;
            r_lda_y1     <= w_head_y;
            r_lda_colour <= w_head_colour;
            r_prev_x     <= w_head_x;
            r_prev_y     <= w_head_y;
            r_end        <= w_head_last;
            r_lda_go     <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_ACK;
        S_ACK:   r_state <= S_WAIT;
        S_WAIT: begin
          if (lda_done) begin
            r_poly_done <= r_end;
            r_state     <= r_end ? S_START : S_NEXT;
          end
        end
        default: r_state <= S_START;
      endcase
    end
  end

  assign fifo_full  = w_full;
  assign overflow   = r_overflow;
  assign busy       = (r_state != S_START) | ~w_empty;
  assign poly_done  = r_poly_done;
  assign lda_go     = r_lda_go;
  assign lda_x0     = r_lda_x0;
  assign lda_x1     = r_lda_x1;
  assign lda_y0     = r_lda_y0;
  assign lda_y1     = r_lda_y1;
  assign lda_colour = r_lda_colour;

endmodule

// File: tb/tb_lda_polyline_sequencer.sv
// Bench for lda_polyline_sequencer: a vertex-to-segment model plus a simple engine model,
// checked every cycle, with literal expectations pinning each directed scenario.
module tb_lda_polyline_sequencer;

  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic       v_push = 1'b0;
  logic [8:0] v_x = '0;
  logic [7:0] v_y = '0;
  logic [2:0] v_colour = '0;
  logic       v_last = 1'b0;
  logic       lda_done = 1'b0;
  logic       fifo_full, overflow, busy, poly_done, lda_go;
  logic [8:0] lda_x0, lda_x1;
  logic [7:0] lda_y0, lda_y1;
  logic [2:0] lda_colour;

  lda_polyline_sequencer #(.DEPTH(8), .AW(3)) dut (
    .clock(clock), .resetN(resetN), .v_push(v_push), .v_x(v_x), .v_y(v_y),
    .v_colour(v_colour), .v_last(v_last), .fifo_full(fifo_full), .overflow(overflow),
    .busy(busy), .poly_done(poly_done), .lda_go(lda_go), .lda_x0(lda_x0), .lda_x1(lda_x1),
    .lda_y0(lda_y0), .lda_y1(lda_y1), .lda_colour(lda_colour), .lda_done(lda_done)
  );

  initial forever #5 clock = ~clock;

  typedef struct {
    int x0; int y0; int x1; int y1; int col; bit last_seg; int cyc;
  } seg_t;

  seg_t exp_q[$];
  seg_t go_log[$];
  bit   ov_exp[int];
  bit   have_prev = 0;
  int   prev_x = 0, prev_y = 0;
  int   n_vec = 0, n_err = 0;
  int   cyc = 0;
  int   eng_mode = 0;   // 0: done pulse in first wait cycle, 1: done held high, 2: done held low
  int   pd_cnt = 0;
  int   last_push_cyc = 0;

  bit   inflight = 0;
  seg_t cur;
  int   go_cyc = 0;
  int   last_go = 0;
  bit   last_go_valid = 0;
  int   pd_due = -1;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Vertex stream -> expected segment list, straight from the polyline rules.
  task automatic model_vertex(input int x, input int y, input int c, input bit last);
    seg_t s;
    s.cyc = 0;
    if (!have_prev) begin
      if (last) begin
        s.x0 = x; s.y0 = y; s.x1 = x; s.y1 = y; s.col = c; s.last_seg = 1;
        exp_q.push_back(s);
      end else begin
        prev_x = x; prev_y = y; have_prev = 1;
      end
    end else begin
      s.x0 = prev_x; s.y0 = prev_y; s.x1 = x; s.y1 = y; s.col = c; s.last_seg = last;
      exp_q.push_back(s);
      prev_x = x; prev_y = y; have_prev = !last;
    end
  endtask

  task automatic push_v(input int x, input int y, input int c, input bit last, input bit drop);
    @(posedge clock);
    #1;
    v_push = 1'b1;
    v_x = 9'(x); v_y = 8'(y); v_colour = 3'(c); v_last = last;
    last_push_cyc = cyc;
    if (drop) ov_exp[cyc + 1] = 1'b1;
    else model_vertex(x, y, c, last);
  endtask

  task automatic end_push();
    @(posedge clock);
    #1;
    v_push = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    bit done_ok;
    done_ok = 0;
    for (int i = 0; i < bound && !done_ok; i++) begin
      @(negedge clock);
      #1;
      if (exp_q.size() == 0 && !inflight && !busy && cyc > pd_due + 1) done_ok = 1;
    end
    if (!done_ok) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: pending=%0d busy=%0d required drained within %0d cycles",
               exp_q.size(), busy, bound);
    end
  endtask

  // Engine model: done one cycle long, two cycles after go, unless held high/low.
  initial begin
    int cd;
    cd = 0;
    forever begin
      @(posedge clock);
      #1;
      if (!resetN) begin
        cd = 0;
        lda_done = 1'b0;
      end else begin
        if (lda_go) cd = 3;
        else if (cd > 0) cd--;
        lda_done = (eng_mode == 1) || (eng_mode == 0 && cd == 1);
      end
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clock);
    if (!resetN) begin
      chk("rst_go", lda_go, 0);
      chk("rst_poly_done", poly_done, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_busy", busy, 0);
      chk("rst_full", fifo_full, 0);
      chk("rst_endpoints", {lda_x0, lda_x1, lda_y0, lda_y1, lda_colour}, 0);
      inflight = 0;
      last_go_valid = 0;
      pd_due = -1;
    end else begin
      chk("poly_done", poly_done, (cyc == pd_due));
      if (poly_done) pd_cnt++;
      chk("overflow", overflow, ov_exp.exists(cyc));
      if (inflight && !lda_go) begin
        chk("hold_x0", lda_x0, cur.x0);
        chk("hold_y0", lda_y0, cur.y0);
        chk("hold_x1", lda_x1, cur.x1);
        chk("hold_y1", lda_y1, cur.y1);
        chk("hold_colour", lda_colour, cur.col);
        if (cyc >= go_cyc + 2 && lda_done) begin
          if (cur.last_seg) pd_due = cyc + 1;
          inflight = 0;
        end
      end
      if (lda_go) begin
        seg_t a;
        a.x0 = lda_x0; a.y0 = lda_y0; a.x1 = lda_x1; a.y1 = lda_y1; a.col = lda_colour;
        a.last_seg = 0; a.cyc = cyc;
        go_log.push_back(a);
        chk("go_while_busy", inflight, 0);
        if (last_go_valid) chk("go_spacing_ge4", (cyc - last_go) >= 4, 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_go", lda_go, 0);
        end else begin
          cur = exp_q.pop_front();
          chk("go_x0", lda_x0, cur.x0);
          chk("go_y0", lda_y0, cur.y0);
          chk("go_x1", lda_x1, cur.x1);
          chk("go_y1", lda_y1, cur.y1);
          chk("go_colour", lda_colour, cur.col);
          inflight = 1;
          go_cyc = cyc;
        end
        last_go = cyc;
        last_go_valid = 1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int pd0;

    repeat (3) @(posedge clock);
    #2 resetN = 1'b1;
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_full", fifo_full, 0);

    // Three-vertex polyline
    eng_mode = 0; base = go_log.size(); pd0 = pd_cnt;
    push_v(10, 20, 1, 0, 0);
    push_v(50, 20, 2, 0, 0);
    push_v(50, 60, 3, 1, 0);
    end_push();
    wait_idle(200);
    chk("t1_go_count", go_log.size() - base, 2);
    chk("t1_pd_count", pd_cnt - pd0, 1);
    if (go_log.size() - base >= 2) begin
      chk("t1_seg0", {go_log[base].x0[8:0], go_log[base].y0[7:0], go_log[base].x1[8:0],
                      go_log[base].y1[7:0], go_log[base].col[2:0]},
          {9'd10, 8'd20, 9'd50, 8'd20, 3'd2});
      chk("t1_seg1", {go_log[base+1].x0[8:0], go_log[base+1].y0[7:0], go_log[base+1].x1[8:0],
                      go_log[base+1].y1[7:0], go_log[base+1].col[2:0]},
          {9'd50, 8'd20, 9'd50, 8'd60, 3'd3});
    end

    // Single terminating vertex
    base = go_log.size(); pd0 = pd_cnt;
    push_v(7, 7, 5, 1, 0);
    end_push();
    wait_idle(100);
    chk("t2_go_count", go_log.size() - base, 1);
    chk("t2_pd_count", pd_cnt - pd0, 1);
    if (go_log.size() > base) begin
      chk("t2_x0_x1", {go_log[base].x0[8:0], go_log[base].x1[8:0]}, {9'd7, 9'd7});
      chk("t2_y0_y1", {go_log[base].y0[7:0], go_log[base].y1[7:0]}, {8'd7, 8'd7});
      chk("t2_colour", go_log[base].col, 5);
      chk("t2_latency", go_log[base].cyc - last_push_cyc, 2);
    end

    // Fill while the engine stalls: two vertices leave as the first segment,
    // eight more fill the FIFO and the eleventh is dropped.
    eng_mode = 2; base = go_log.size(); pd0 = pd_cnt;
    for (int i = 1; i <= 11; i++)
      push_v(i * 30 % 320, i * 20, i % 8, (i == 10), (i == 11));
    end_push();
    repeat (3) @(posedge clock);
    #1;
    chk("t3_full", fifo_full, 1);
    chk("t3_busy", busy, 1);
    eng_mode = 1;
    wait_idle(400);
    chk("t3_go_count", go_log.size() - base, 9);
    chk("t3_pd_count", pd_cnt - pd0, 1);
    if (go_log.size() - base >= 9)
      chk("t3_last_seg", {go_log[base+8].x1[8:0], go_log[base+8].y1[7:0], go_log[base+8].col[2:0]},
          {9'd300, 8'd200, 3'd2});
    chk("t3_full_drained", fifo_full, 0);

    // Two polylines back to back
    eng_mode = 0; base = go_log.size(); pd0 = pd_cnt;
    push_v(0, 0, 1, 0, 0);
    push_v(5, 5, 2, 1, 0);
    push_v(100, 100, 3, 0, 0);
    push_v(101, 100, 4, 1, 0);
    end_push();
    wait_idle(200);
    chk("t4_go_count", go_log.size() - base, 2);
    chk("t4_pd_count", pd_cnt - pd0, 2);
    if (go_log.size() - base >= 2)
      chk("t4_seg1", {go_log[base+1].x0[8:0], go_log[base+1].y0[7:0], go_log[base+1].x1[8:0]},
          {9'd100, 8'd100, 9'd101});

    // Reset while waiting on the engine with three vertices still queued
    eng_mode = 2;
    for (int i = 0; i < 5; i++) push_v(20 + i, 30 + i, 1, 0, 0);
    end_push();
    repeat (4) @(posedge clock);
    #1;
    chk("t5_busy_before", busy, 1);
    @(posedge clock);
    #2 resetN = 1'b0;
    exp_q.delete();
    ov_exp.delete();
    have_prev = 0;
    #1;
    chk("t5_go_in_rst", lda_go, 0);
    chk("t5_busy_in_rst", busy, 0);
    repeat (2) @(posedge clock);
    #2 resetN = 1'b1;
    eng_mode = 0; base = go_log.size(); pd0 = pd_cnt;
    push_v(30, 40, 6, 1, 0);
    end_push();
    wait_idle(100);
    chk("t5_go_count", go_log.size() - base, 1);
    chk("t5_pd_count", pd_cnt - pd0, 1);
    if (go_log.size() > base)
      chk("t5_seg", {go_log[base].x0[8:0], go_log[base].x1[8:0], go_log[base].col[2:0]},
          {9'd30, 9'd30, 3'd6});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
